// File: rtl/cpu_interlock_pkg.sv
// cpu_interlock_pkg: mox125 opcodes, interlock state encoding and op-class helpers.
package cpu_interlock_pkg;
  localparam int ILK_STATE_WIDTH = 3;
  typedef enum logic [ILK_STATE_WIDTH-1:0] {
    ILK_RUN    = 3'd0,
    ILK_LDWAIT = 3'd1,
    ILK_MCWAIT = 3'd2,
    ILK_FLUSH  = 3'd3,
    ILK_HALT   = 3'd4
  } ilk_state_t;
  localparam logic [6:0] OP_ADD_L  = 7'h05;
  localparam logic [6:0] OP_POP    = 7'h07;
  localparam logic [6:0] OP_LDA_L  = 7'h08;
  localparam logic [6:0] OP_LD_L   = 7'h0a;
  localparam logic [6:0] OP_LDO_L  = 7'h0c;
  localparam logic [6:0] OP_NOP    = 7'h0f;
  localparam logic [6:0] OP_LD_B   = 7'h1c;
  localparam logic [6:0] OP_LDA_B  = 7'h1d;
  localparam logic [6:0] OP_LD_S   = 7'h21;
  localparam logic [6:0] OP_LDA_S  = 7'h22;
  localparam logic [6:0] OP_MUL_L  = 7'h2f;
  localparam logic [6:0] OP_DIV_L  = 7'h31;
  localparam logic [6:0] OP_UDIV_L = 7'h32;
  localparam logic [6:0] OP_MOD_L  = 7'h33;
  localparam logic [6:0] OP_UMOD_L = 7'h34;
  localparam logic [6:0] OP_BRK    = 7'h35;
  localparam logic [6:0] OP_LDO_B  = 7'h36;
  localparam logic [6:0] OP_LDO_S  = 7'h38;
  function automatic logic is_load(input logic [6:0] op);
    return op inside {OP_LD_B, OP_LD_S, OP_LD_L, OP_LDA_B, OP_LDA_S, OP_LDA_L,
                      OP_LDO_B, OP_LDO_S, OP_LDO_L, OP_POP};
  endfunction
  function automatic logic is_mc(input logic [6:0] op);
    return op inside {OP_MUL_L, OP_DIV_L, OP_UDIV_L, OP_MOD_L, OP_UMOD_L};
  endfunction
endpackage

// File: rtl/cpu_interlock_if.sv
// cpu_interlock_if: decode/fetch/execute view of the interlock; resume_i exists only with INTERLOCK_BRK_HALT_EN.
interface cpu_interlock_if;
  import cpu_interlock_pkg::*;
  logic [6:0] op_i;
  logic wa_i;
  logic [3:0] wa_index_i;
  logic next_valid_i;
  logic [3:0] next_riA_i;
  logic [3:0] next_riB_i;
  logic branch_taken_i;
  logic mc_done_i;
`ifdef INTERLOCK_BRK_HALT_EN
  logic resume_i;
`endif
  logic stall_o;
  logic flush_o;
  logic bubble_o;
  logic halted_o;
  logic [ILK_STATE_WIDTH-1:0] state_o;
  modport master (
    output
`ifdef INTERLOCK_BRK_HALT_EN
    resume_i,
`endif
    op_i, wa_i, wa_index_i, next_valid_i, next_riA_i, next_riB_i, branch_taken_i, mc_done_i,
    input stall_o, flush_o, bubble_o, halted_o, state_o
  );
  modport slave (
    input
`ifdef INTERLOCK_BRK_HALT_EN
    resume_i,
`endif
    op_i, wa_i, wa_index_i, next_valid_i, next_riA_i, next_riB_i, branch_taken_i, mc_done_i,
    output stall_o, flush_o, bubble_o, halted_o, state_o
  );
endinterface

// File: rtl/stall_counter.sv
// stall_counter: 4-bit loadable down-counter; zero_next flags the cycle whose decrement reaches zero.
module stall_counter (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       load,
  input  logic       dec,
  input  logic [3:0] load_val,
  output logic       zero_next
);
  logic [3:0] cnt;
  always_ff @(posedge clk_i)
    cnt <= rst_i ? 4'd0 : load ? load_val : (dec && cnt != 4'd0) ? cnt - 4'd1 : cnt;
  assign zero_next = cnt <= 4'd1;
endmodule

// File: rtl/cpu_interlock.sv
// cpu_interlock: mox125 load-use / mul-div / branch-flush interlock FSM.
// Define INTERLOCK_BRK_HALT_EN to add the BRK halt state and resume_i.
module cpu_interlock import cpu_interlock_pkg::*; #(
  parameter int LOAD_LAT     = 2,
  parameter int FLUSH_CYCLES = 2
) (
  input logic           clk_i,
  input logic           rst_i,
  cpu_interlock_if.slave bus
);
  if (LOAD_LAT < 1 || LOAD_LAT > 15 || FLUSH_CYCLES < 1 || FLUSH_CYCLES > 15) begin : g_bad_param
    $error("cpu_interlock: LOAD_LAT and FLUSH_CYCLES must be within 1..15");
  end
  // The entry cycle already counts as one stall/flush cycle, so a 1-cycle wait never leaves RUN.
  localparam ilk_state_t BR_DST = FLUSH_CYCLES > 1 ? ILK_FLUSH : ILK_RUN;
  localparam ilk_state_t LD_DST = LOAD_LAT > 1 ? ILK_LDWAIT : ILK_RUN;
  localparam logic [3:0] FL_VAL = 4'(FLUSH_CYCLES - 1);
  localparam logic [3:0] LD_VAL = 4'(LOAD_LAT - 1);
  ilk_state_t state, state_nxt;
  logic hazard, brk, mc_hit, ld_hit, br, load, zero_next, stall, flush, bubble;
  logic [3:0] load_val;
  assign hazard = bus.wa_i & bus.next_valid_i &
                  (bus.wa_index_i == bus.next_riA_i | bus.wa_index_i == bus.next_riB_i);
`ifdef INTERLOCK_BRK_HALT_EN
  assign brk = bus.op_i == OP_BRK;
`else
  assign brk = 1'b0;
`endif
  assign mc_hit = is_mc(bus.op_i);
  assign ld_hit = is_load(bus.op_i) & hazard;
  assign br = bus.branch_taken_i & (state != ILK_HALT);
  always_comb begin
    state_nxt = state;
    load = 1'b0;
    load_val = FL_VAL;
    case (state)
      ILK_RUN:
        if (br) begin
          state_nxt = BR_DST;
          load = 1'b1;
        end else if (brk) state_nxt = ILK_HALT;
        else if (mc_hit) state_nxt = bus.mc_done_i ? ILK_RUN : ILK_MCWAIT;
        else if (ld_hit) begin
          state_nxt = LD_DST;
          load = 1'b1;
          load_val = LD_VAL;
        end
      ILK_LDWAIT, ILK_FLUSH:
        if (br) begin
          state_nxt = BR_DST;
          load = 1'b1;
        end else if (zero_next) state_nxt = ILK_RUN;
      ILK_MCWAIT:
        if (br) begin
          state_nxt = BR_DST;
          load = 1'b1;
        end else if (bus.mc_done_i) state_nxt = ILK_RUN;
`ifdef INTERLOCK_BRK_HALT_EN
      ILK_HALT:
        if (bus.resume_i) state_nxt = ILK_RUN;
`endif
      default: state_nxt = ILK_RUN;
    endcase
  end
  always_ff @(posedge clk_i) begin
    state <= rst_i ? ILK_RUN : state_nxt;
    bubble <= rst_i ? 1'b0 : stall | flush;
  end
  stall_counter u_cnt (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .load     (load),
    .dec      (state == ILK_LDWAIT || state == ILK_FLUSH),
    .load_val (load_val),
    .zero_next(zero_next)
  );
  assign flush = br | (state == ILK_FLUSH);
  assign stall = ~flush & ((state inside {ILK_LDWAIT, ILK_MCWAIT, ILK_HALT}) |
                           (state == ILK_RUN & (brk | mc_hit | ld_hit)));
  assign bus.stall_o = stall;
  assign bus.flush_o = flush;
  assign bus.bubble_o = bubble;
  assign bus.state_o = state;
`ifdef INTERLOCK_BRK_HALT_EN
  assign bus.halted_o = state == ILK_HALT;
`else
  assign bus.halted_o = 1'b0;
`endif
endmodule
